uart_cmd_bridge: RTL and testbench

//  Parametrised UART command bridge between a host serial link and a memory-style controller (PSRAM ctrl).

---
 rtl/uart_bridge_pkg.sv | 19 +
 rtl/uart_byte_rx.sv | 115 +++++++++++
 rtl/uart_cmd_bridge.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART command bridge: protocol opcodes and
// parser state encodings.
package uart_bridge_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_ABORT = 8'h2F;  // '/'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_ADDR  = 3'd1,
    P_DATA  = 3'd2,
    P_ISSUE = 3'd3,
    P_RSP   = 3'd4,
    P_TX    = 3'd5
  } parser_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling, stop-bit framing check and a one-cycle byte strobe
// that appears the cycle after the stop-bit sample.
module uart_byte_rx #(
  parameter int CLK_DIV = 234
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       strobe_o,
  output logic       frame_err_o
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;

  assign rx_s        = sync_q[1];
  assign data_o      = shift_q;
  assign strobe_o    = strobe_q;
  assign frame_err_o = ferr_q;

  // Synchronise the asynchronous line and keep last value for edge detect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  // Frame sampler state and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= R_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state: half-bit to the start centre, then full bits to each centre
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          // A line that is high again at mid-start was only a glitch
          state_d = rx_s ? R_IDLE : R_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          state_d  = R_IDLE;
          cnt_d    = '0;
          strobe_d = rx_s;
          ferr_d   = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses framed R/W commands from the serial link,
// issues them over a valid/ready handshake, and returns read data or a
// write acknowledge over TX.
module uart_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLK_DIV      = 234,
  parameter int ADDR_BYTES   = 3,
  parameter int DATA_BYTES   = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    uart_rx_i,
  output logic                    uart_tx_o,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic [8*ADDR_BYTES-1:0] cmd_addr_o,
  output logic [8*DATA_BYTES-1:0] cmd_wdata_o,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  input  logic [8*DATA_BYTES-1:0] rsp_data_i,
  output logic                    err_frame_o,
  output logic                    err_cmd_o,
  output logic                    busy_o
);

  localparam int AW      = 8 * ADDR_BYTES;
  localparam int DW      = 8 * DATA_BYTES;
  localparam int MAXB    = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BC_W    = $clog2(MAXB + 1);
  localparam int BL_W    = $clog2(DATA_BYTES + 1);
  localparam int CW      = $clog2(CLK_DIV);
  localparam int TO_W    = $clog2(TIMEOUT_BITS * CLK_DIV) + 1;
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_BITS * CLK_DIV - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLK_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_ferr;

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk_i      (sys_clk_i),
    .rst_i      (sys_rst_i),
    .rx_i       (uart_rx_i),
    .data_o     (rx_byte),
    .strobe_o   (rx_strobe),
    .frame_err_o(rx_ferr)
  );

  parser_state_t   state_q, state_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   addr_sh_q, addr_sh_d;
  logic [DW-1:0]   data_sh_q, data_sh_d;
  logic            wr_sh_q, wr_sh_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_cmd_q, err_cmd_d;
  logic [AW-1:0]   cmd_addr_q;
  logic [DW-1:0]   cmd_wdata_q;
  logic            cmd_write_q;
  logic            issue_load;
  logic            timeout_hit;

  logic            tx_start;
  logic [DW-1:0]   tx_word;
  logic [BL_W-1:0] tx_bytes;
  logic            tx_done;

  logic            tx_q;
  logic            tx_active_q;
  logic [8:0]      tx_shift_q;
  logic [DW-1:0]   tx_buf_q;
  logic [3:0]      tx_bits_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [BL_W-1:0] tx_left_q;

  assign timeout_hit = (to_cnt_q == TO_LIM);
  assign issue_load  = (state_d == P_ISSUE) && (state_q != P_ISSUE);
  assign tx_done     = tx_active_q && (tx_cnt_q == FULL_M1) && (tx_bits_q == 4'd9)
                       && (tx_left_q == BL_W'(1));

  assign uart_tx_o   = tx_q;
  assign cmd_valid_o = (state_q == P_ISSUE);
  assign rsp_ready_o = (state_q == P_RSP);
  assign busy_o      = (state_q != P_IDLE);
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_wdata_o = cmd_wdata_q;
  assign cmd_write_o = cmd_write_q;
  assign err_frame_o = rx_ferr;
  assign err_cmd_o   = err_cmd_q;

  // Parser registers; command outputs only change when a new command issues
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= P_IDLE;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      wr_sh_q     <= 1'b0;
      to_cnt_q    <= '0;
      err_cmd_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      wr_sh_q    <= wr_sh_d;
      to_cnt_q   <= to_cnt_d;
      err_cmd_q  <= err_cmd_d;
      if (issue_load) begin
        cmd_addr_q  <= addr_sh_d;
        cmd_write_q <= wr_sh_q;
        if (wr_sh_q) cmd_wdata_q <= data_sh_d;
      end
    end
  end

  // Parser next-state, timeout counter and TX launch request
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    wr_sh_d    = wr_sh_q;
    err_cmd_d  = 1'b0;
    tx_start   = 1'b0;
    tx_word    = rsp_data_i;
    tx_bytes   = BL_W'(DATA_BYTES);
    case (state_q)
      P_IDLE: begin
        if (rx_strobe) begin
          if (rx_byte == OP_READ || rx_byte == OP_WRITE) begin
            state_d    = P_ADDR;
            wr_sh_d    = (rx_byte == OP_WRITE);
            byte_cnt_d = '0;
          end else if (rx_byte != OP_ABORT) begin
            err_cmd_d = 1'b1;
          end
        end
      end
      P_ADDR: begin
        if (rx_ferr) begin
          state_d = P_IDLE;
        end else if (rx_strobe) begin
          if (rx_byte == OP_ABORT) begin
            state_d = P_IDLE;
          end else begin
            addr_sh_d = (addr_sh_q << 8) | AW'(rx_byte);
            if (byte_cnt_q == BC_W'(ADDR_BYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = wr_sh_q ? P_DATA : P_ISSUE;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end else if (timeout_hit) begin
          state_d   = P_IDLE;
          err_cmd_d = 1'b1;
        end
      end
      P_DATA: begin
        if (rx_ferr) begin
          state_d = P_IDLE;
        end else if (rx_strobe) begin
          if (rx_byte == OP_ABORT) begin
            state_d = P_IDLE;
          end else begin
            data_sh_d = (data_sh_q << 8) | DW'(rx_byte);
            if (byte_cnt_q == BC_W'(DATA_BYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = P_ISSUE;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end else if (timeout_hit) begin
          state_d   = P_IDLE;
          err_cmd_d = 1'b1;
        end
      end
      P_ISSUE: begin
        if (rx_strobe) err_cmd_d = 1'b1;
        if (cmd_ready_i) begin
          if (wr_sh_q) begin
            state_d  = P_TX;
            tx_start = 1'b1;
            tx_word  = DW'(RSP_ACK) << (DW - 8);
            tx_bytes = BL_W'(1);
          end else begin
            state_d = P_RSP;
          end
        end
      end
      P_RSP: begin
        if (rx_strobe) err_cmd_d = 1'b1;
        if (rsp_valid_i) begin
          state_d  = P_TX;
          tx_start = 1'b1;
        end
      end
      P_TX: begin
        if (rx_strobe) err_cmd_d = 1'b1;
        if (tx_done) state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase

    // Inter-byte timer only runs while a command is being collected
    if (rx_strobe || !(state_q == P_ADDR || state_q == P_DATA)) begin
      to_cnt_d = '0;
    end else if (!timeout_hit) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // TX shifter: start bit, 8 data bits LSB-first, stop bit, bytes back-to-back
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      tx_shift_q  <= 9'h1FF;
      tx_buf_q    <= '0;
      tx_bits_q   <= '0;
      tx_cnt_q    <= '0;
      tx_left_q   <= '0;
    end else if (tx_start) begin
      tx_q        <= 1'b0;
      tx_active_q <= 1'b1;
      tx_shift_q  <= {1'b1, tx_word[DW-1 -: 8]};
      tx_buf_q    <= tx_word << 8;
      tx_bits_q   <= '0;
      tx_cnt_q    <= '0;
      tx_left_q   <= tx_bytes;
    end else if (tx_active_q) begin
      if (tx_cnt_q == FULL_M1) begin
        tx_cnt_q <= '0;
        if (tx_bits_q == 4'd9) begin
          if (tx_left_q == BL_W'(1)) begin
            tx_active_q <= 1'b0;
            tx_left_q   <= '0;
            tx_q        <= 1'b1;
          end else begin
            tx_left_q  <= tx_left_q - 1'b1;
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, tx_buf_q[DW-1 -: 8]};
            tx_buf_q   <= tx_buf_q << 8;
            tx_bits_q  <= '0;
          end
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bits_q  <= tx_bits_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for the UART command bridge at CLK_DIV=16.
module tb_uart_cmd_bridge;

  localparam int CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data = 16'h0000;
  logic        uart_tx, cmd_valid, cmd_write, rsp_ready, err_frame, err_cmd, busy;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;

  always #5 clk = ~clk;

  uart_cmd_bridge #(
    .CLK_DIV(CLK_DIV), .ADDR_BYTES(3), .DATA_BYTES(2), .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .uart_rx_i  (rx),
    .uart_tx_o  (uart_tx),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready),
    .cmd_write_o(cmd_write),
    .cmd_addr_o (cmd_addr),
    .cmd_wdata_o(cmd_wdata),
    .rsp_valid_i(rsp_valid),
    .rsp_ready_o(rsp_ready),
    .rsp_data_i (rsp_data),
    .err_frame_o(err_frame),
    .err_cmd_o  (err_cmd),
    .busy_o     (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int n_err_cmd = 0, n_err_frame = 0, n_cmd_valid = 0, tx_bad = 0;
  logic [7:0] txq[$];

  // Count output pulses and cycles of interest
  always @(posedge clk) begin
    if (err_cmd)   n_err_cmd   <= n_err_cmd + 1;
    if (err_frame) n_err_frame <= n_err_frame + 1;
    if (cmd_valid) n_cmd_valid <= n_cmd_valid + 1;
  end

  // Serial receiver model for the TX line
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (CLK_DIV / 2) @(posedge clk);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(posedge clk);
        if (uart_tx === 1'b1) txq.push_back(b);
        else tx_bad++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CLK_DIV);
    end
    rx = stop;
    tick(CLK_DIV);
    rx = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input int bound);
    int k = 0;
    while (txq.size() < n && k < bound) begin
      tick(1);
      k++;
    end
    check("tx_byte_count", txq.size(), n);
  endtask

  function automatic logic [7:0] pop_tx();
    if (txq.size() > 0) return txq.pop_front();
    return 8'hxx;
  endfunction

  initial begin : stim
    int e0, f0, v0;
    // Reset, then a frame cut short by a second reset
    tick(4);
    check("rst_tx_idle", uart_tx, 1);
    rst = 1'b0;
    tick(4);
    rx = 1'b0; tick(16); rx = 1'b1; tick(16); rx = 1'b0; tick(16);
    rst = 1'b1; rx = 1'b1;
    tick(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_errs", {err_frame, err_cmd}, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_wdata_write", {cmd_wdata, cmd_write}, 0);
    rst = 1'b0;
    tick(32);
    check("midframe_discard", n_err_cmd + n_err_frame, 0);

    // Read 0x000010, with a stray byte during the response wait
    send_byte(8'h52, 1'b1);
    check("rd_busy_after_op", busy, 1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    check("rd_cmd_valid", cmd_valid, 1);
    check("rd_cmd_write", cmd_write, 0);
    check("rd_cmd_addr", cmd_addr, 24'h000010);
    check("rd_rsp_ready_early", rsp_ready, 0);
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    check("rd_cmd_valid_drop", cmd_valid, 0);
    check("rd_rsp_ready", rsp_ready, 1);
    e0 = n_err_cmd;
    send_byte(8'h33, 1'b1);
    check("rsp_drop_err_cmd", n_err_cmd - e0, 1);
    check("rsp_still_waiting", rsp_ready, 1);
    rsp_data = 16'hA55A; rsp_valid = 1'b1; tick(1); rsp_valid = 1'b0; rsp_data = 16'h0000;
    check("rd_rsp_ready_drop", rsp_ready, 0);
    wait_tx(2, 600);
    check("rd_tx_byte0", pop_tx(), 8'hA5);
    check("rd_tx_byte1", pop_tx(), 8'h5A);
    check("rd_busy_in_stop", busy, 1);
    tick(12);
    check("rd_busy_done", busy, 0);
    check("rd_tx_idle", uart_tx, 1);

    // Write 0xBEEF to 0x012345 with a delayed ready
    txq.delete();
    send_byte(8'h57, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    check("wr_cmd_valid", cmd_valid, 1);
    tick(10);
    check("wr_cmd_valid_held", cmd_valid, 1);
    check("wr_cmd_write", cmd_write, 1);
    check("wr_cmd_addr", cmd_addr, 24'h012345);
    check("wr_cmd_wdata", cmd_wdata, 16'hBEEF);
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    check("wr_cmd_valid_drop", cmd_valid, 0);
    wait_tx(1, 400);
    check("wr_tx_ack", pop_tx(), 8'h4B);
    tick(12);
    check("wr_busy_done", busy, 0);
    check("wr_addr_held", cmd_addr, 24'h012345);

    // Unknown opcode
    e0 = n_err_cmd;
    send_byte(8'h41, 1'b1);
    check("badop_err_cmd", n_err_cmd - e0, 1);
    check("badop_idle", busy, 0);

    // Inter-byte timeout in the address phase
    e0 = n_err_cmd; v0 = n_cmd_valid;
    send_byte(8'h57, 1'b1); send_byte(8'h01, 1'b1);
    tick(300);
    check("to_not_yet", {busy, 31'(n_err_cmd - e0)}, {1'b1, 31'd0});
    tick(40);
    check("to_err_cmd", n_err_cmd - e0, 1);
    check("to_idle", busy, 0);
    check("to_no_cmd", n_cmd_valid - v0, 0);

    // Framing error during the address phase
    e0 = n_err_cmd; f0 = n_err_frame; v0 = n_cmd_valid;
    send_byte(8'h52, 1'b1);
    send_byte(8'h11, 1'b0);
    check("ferr_pulse", n_err_frame - f0, 1);
    check("ferr_no_err_cmd", n_err_cmd - e0, 0);
    check("ferr_idle", busy, 0);
    check("ferr_no_cmd", n_cmd_valid - v0, 0);
    tick(16);

    // Silent abort mid-address
    e0 = n_err_cmd; v0 = n_cmd_valid;
    send_byte(8'h52, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h2F, 1'b1);
    check("abort_idle", busy, 0);
    check("abort_no_err", n_err_cmd - e0, 0);
    check("abort_no_cmd", n_cmd_valid - v0, 0);
    check("tx_frames_clean", tx_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
